// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Holds the FSM state type, the key-code lookup table and the default timing values.
package keypad_pkg;

  localparam int SCAN_DIV_DEF        = 2000;
  localparam int DEBOUNCE_CYCLES_DEF = 50000;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Nibble at index {row, col} is the hex code printed on that key.
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col, 2'b00} +: 4];
  endfunction

  // Position of the single low bit; only meaningful when exactly one bit is low.
  function automatic logic [1:0] row_index(input logic [3:0] rs);
    logic [1:0] idx;
    case (rs)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
// Flops reset to RESET_VAL so an idle (pulled-up) bus reads as inactive after reset.
module sync2 #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates the active-low column drive, debounces a single-key
// press and its release, and reports the accepted key plus a two-digit history.
import keypad_pkg::*;

module keypad_scanner #(
  parameter int SCAN_DIV        = SCAN_DIV_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_val,
  output logic       key_valid,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output state_t     dbg_state
);

  localparam int MAX_DIV = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(MAX_DIV) + 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [3:0]    rs;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    pat_q, pat_d;
  logic [3:0]    key_val_q, key_val_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    dnew_q, dnew_d;
  logic [3:0]    dold_q, dold_d;
  logic          one_low;
  logic [3:0]    code;

  sync2 #(.WIDTH(4), .RESET_VAL(4'hF)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rows),
    .q       (rs)
  );

  assign one_low = ($countones(~rs) == 1);
  assign code    = key_code(row_q, col_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SCAN;
      cnt_q       <= '0;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      pat_q       <= 4'hF;
      key_val_q   <= 4'h0;
      key_valid_q <= 1'b0;
      dnew_q      <= 4'h0;
      dold_q      <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pat_q       <= pat_d;
      key_val_q   <= key_val_d;
      key_valid_q <= key_valid_d;
      dnew_q      <= dnew_d;
      dold_q      <= dold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    pat_d       = pat_q;
    key_val_d   = key_val_q;
    key_valid_d = 1'b0;
    dnew_d      = dnew_q;
    dold_d      = dold_q;
    case (state_q)
      SCAN: begin
        // Rows are only trusted at the end of a dwell, once the new column has settled.
        if (cnt_q >= SCAN_LAST) begin
          cnt_d = '0;
          if (one_low) begin
            row_d   = row_index(rs);
            pat_d   = rs;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DEBOUNCE: begin
        if (rs != pat_q) begin
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
          state_d = SCAN;
        end else if (cnt_q >= DB_LAST) begin
          cnt_d       = '0;
          key_valid_d = 1'b1;
          key_val_d   = code;
          dold_d      = dnew_q;
          dnew_d      = code;
          state_d     = HELD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (rs == 4'hF) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Any low row, including a second key, restarts the release wait.
        if (rs != 4'hF) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q >= DB_LAST) begin
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = SCAN;
      end
    endcase
  end

  assign cols      = ~(4'b0001 << col_q);
  assign key_val   = key_val_q;
  assign key_valid = key_valid_q;
  assign digit_new = dnew_q;
  assign digit_old = dold_q;
  assign dbg_state = state_q;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 2000, which sets the clock cycles each column is driven during scanning (minimum 2).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, which sets the stable cycles needed to accept a press or a release (minimum 2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 rows  input  4  keypad row lines; active-low, pulled up, asynchronous to clk.
REQ-006 cols  output  4  keypad column drive; active-low, exactly one bit low at all times.
REQ-007 key_val  output  4  hex code of the most recently accepted key.
REQ-008 key_valid  output  1  one-cycle pulse when a key press is accepted.
REQ-009 digit_new  output  4  most recent accepted digit; feeds the 7-segment decoder.
REQ-010 digit_old  output  4  previous accepted digit; feeds the 7-segment decoder.

Function
REQ-011 rows SHALL pass through a 2-flop synchronizer; all decisions SHALL use only the synchronized value (rs).
REQ-012 The FSM SHALL have four states:
- SCAN: step columns.
- DEBOUNCE: confirm a press.
- HELD: wait for release.
- RELEASE: confirm a release.
REQ-013 In SCAN, cols SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing every SCAN_DIV cycles.
REQ-014 In SCAN, rs SHALL be evaluated only on the last cycle of each column dwell.
REQ-015 On that last cycle, if exactly one rs bit is low, the FSM SHALL latch row and column indices, hold cols, clear the counter and enter DEBOUNCE; otherwise it SHALL advance the column.
REQ-016 If two or more rs bits are low, the block SHALL treat it as no key and keep scanning.
REQ-017 In DEBOUNCE, any cycle with rs different from the latched pattern SHALL return the FSM to SCAN with the next column and no key_valid pulse.
REQ-018 If rs matches for DEBOUNCE_CYCLES consecutive cycles, the block SHALL, in the next cycle:
- assert key_valid for exactly one cycle;
- load key_val;
- shift digit_old <= digit_new and digit_new <= key code;
- enter HELD.
REQ-019 Key code map (row r, column c) SHALL be:
- r0: 1 2 3 A
- r1: 4 5 6 B
- r2: 7 8 9 C
- r3: E 0 F D
REQ-020 In HELD, cols SHALL stay frozen and no further key_valid SHALL occur; rs == 4'hF SHALL clear the counter and enter RELEASE.
REQ-021 In RELEASE, any low rs bit SHALL return the FSM to HELD; DEBOUNCE_CYCLES consecutive all-high cycles SHALL enter SCAN at the next column.
REQ-022 A second key pressed while one is held SHALL be ignored until full release completes.
REQ-023 Counters SHALL saturate-compare, never wrap; counter width SHALL be $clog2 of the larger parameter plus 1.
REQ-024 key_val, digit_new and digit_old SHALL hold their values between accepted presses.

Reset
REQ-025 While reset_n is low, outputs SHALL be: cols = 4'b1110, key_val = 0, key_valid = 0, digit_new = 0, digit_old = 0.
REQ-026 While reset_n is low, internal state SHALL be: state = SCAN, counters = 0, synchronizer flops = 4'hF.
REQ-027 Reset asserted mid-DEBOUNCE or mid-HELD SHALL abort with no key_valid pulse; scanning SHALL restart at column 0 after reset_n rises.

Structure
REQ-028 A shared package keypad_pkg SHALL hold the state enum type, the 4x4 key-code lookup constant and the default parameter values.
REQ-029 The synchronizer SHALL be a sub-module sync2 (parameterised width), instantiated once with width 4.
REQ-030 The column rotator, counters and FSM SHALL reside in keypad_scanner; the 7-segment decoder SHALL stay external.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-031 Reset release, no key -> cols cycles 1110,1101,1011,0111 every 4 clks; key_valid never high.
REQ-032 Hold row1 low while cols=1101 -> key_valid single pulse 8 clks after DEBOUNCE entry; key_val=5, digit_new=5, digit_old=0.
REQ-033 Then press r3/c1 and release cleanly -> digit_new=0, digit_old=5; exactly one pulse per press.
REQ-034 Bounce: row0 low 3 clks then high during DEBOUNCE -> no pulse; scanning resumes at next column.
REQ-035 Hold key, add a second key in another row -> no second pulse; after both released for 8 clks, scanning resumes.
REQ-036 Assert reset_n low at DEBOUNCE count 5 -> all outputs at reset values immediately; no pulse; cols=1110 after release.
